// File: rtl/function_even_parity.sv
// -----------------------------------------------------------------------------
// function_even_parity
// Streaming even-parity generator (and optional checker) on a valid/ready
// byte stream. Each accepted word is registered together with its even-parity
// bit (XOR of all data bits). The parity computation is exposed as the
// automatic function parity_even() so parents and benches can call it
// hierarchically.
//
// Build option: define FUNCTION_EVEN_PARITY_CHECK_EN to build the checker
// (in_par compare, out_err, saturating err_cnt, clr_cnt). Without it, out_err
// and err_cnt are tied to 0 and in_par / clr_cnt are ignored.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  input handshake; in_ready = !out_valid || out_ready
//   in_data, in_par data word and received parity bit
//   out_valid/ready output handshake
//   out_data        registered copy of in_data
//   out_par         even-parity bit of out_data
//   out_err         received parity did not match computed parity
//   clr_cnt         synchronous clear of err_cnt (wins over increment)
//   err_cnt         saturating mismatch count
// -----------------------------------------------------------------------------
module function_even_parity #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_par,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_par,
   output logic              out_err,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  err_cnt
);

   // Even-parity bit: data plus this bit always holds an even number of ones.
   function automatic logic parity_even(input logic [DATA_W-1:0] data);
      return ^data;
   endfunction

   logic              accept_c;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic              out_par_q,   out_par_d;

   // The output slot frees up in the same cycle the consumer takes it.
   assign in_ready = !out_valid_q || out_ready;
   assign accept_c = in_valid && in_ready;

   // Generator datapath: load on accept, drop valid when drained, else hold.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_par_d   = out_par_q;
      if (accept_c) begin
         out_valid_d = 1'b1;
         out_data_d  = in_data;
         out_par_d   = parity_even(in_data);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_par_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_par_q   <= out_par_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_par   = out_par_q;

`ifdef FUNCTION_EVEN_PARITY_CHECK_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             beat_err_c;
   logic             out_err_q, out_err_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

   // Checker: flag mismatch with the beat, count it saturating; clear wins.
   always_comb begin
      beat_err_c = (in_par != parity_even(in_data));
      out_err_d  = out_err_q;
      err_cnt_d  = err_cnt_q;
      if (accept_c) begin
         out_err_d = beat_err_c;
      end
      if (clr_cnt) begin
         err_cnt_d = '0;
      end else if (accept_c && beat_err_c && (err_cnt_q != CNT_MAX)) begin
         err_cnt_d = err_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_err_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         out_err_q <= out_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign out_err = out_err_q;
   assign err_cnt = err_cnt_q;
`else
   // Checker not built: ports stay, inputs are intentionally sunk.
   logic unused_chk;
   assign unused_chk = ^{in_par, clr_cnt};
   assign out_err    = 1'b0;
   assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_function_even_parity.sv
// -----------------------------------------------------------------------------
// tb_function_even_parity
// Self-checking bench for function_even_parity. A scoreboard queue receives the
// expected (data, parity, err) on every accepted beat and is popped and compared
// whenever the DUT hands a beat to the consumer. A second instance with
// CNT_W=2 exercises counter saturation and clear priority. Checker-dependent
// expectations follow FUNCTION_EVEN_PARITY_CHECK_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_function_even_parity;

`ifdef FUNCTION_EVEN_PARITY_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic       par;
      logic       err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_par, out_valid, out_ready;
   logic [7:0]  in_data, out_data;
   logic        out_par, out_err, clr_cnt;
   logic [15:0] err_cnt;

   logic        v2, rdy2, p2, ov2, or2, op2, oe2, clr2;
   logic [7:0]  d2, od2;
   logic [1:0]  cnt2;

   int   checks = 0;
   int   errors = 0;
   int   cnt_model = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   function_even_parity #(.DATA_W(8), .CNT_W(16)) uut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_par(in_par), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_par(out_par),
      .out_err(out_err), .clr_cnt(clr_cnt), .err_cnt(err_cnt)
   );

   function_even_parity #(.DATA_W(8), .CNT_W(2)) uut2 (
      .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2),
      .in_data(d2), .in_par(p2), .out_valid(ov2),
      .out_ready(or2), .out_data(od2), .out_par(op2),
      .out_err(oe2), .clr_cnt(clr2), .err_cnt(cnt2)
   );

   // Scoreboard: compare the beat being consumed, then record a newly accepted one.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         sb.delete();
         cnt_model = 0;
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected_beat: got data=%h, expected no beat", out_data);
            end else begin
               e = sb.pop_front();
               if ({out_data, out_par, out_err} !== {e.data, e.par, e.err}) begin
                  errors++;
                  $display("FAIL sb_beat: got data=%h par=%b err=%b, expected data=%h par=%b err=%b",
                           out_data, out_par, out_err, e.data, e.par, e.err);
               end
            end
         end
         if (in_valid && in_ready) begin
            e.data = in_data;
            e.par  = ^in_data;
            e.err  = CHK && (in_par != (^in_data));
            sb.push_back(e);
            if (e.err && cnt_model < 65535) cnt_model++;
         end
         if (clr_cnt && CHK) cnt_model = 0;
      end
   end

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_par = 1'b0;
      out_ready = 1'b1; clr_cnt = 1'b0;
      v2 = 1'b0; d2 = '0; p2 = 1'b0; clr2 = 1'b0; or2 = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checks += 6;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, expected 0", out_valid); end
      if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h, expected 00", out_data); end
      if (out_par !== 1'b0) begin errors++; $display("FAIL rst_out_par: got %b, expected 0", out_par); end
      if (out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err: got %b, expected 0", out_err); end
      if (err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err_cnt: got %0d, expected 0", err_cnt); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, expected 1", in_ready); end
   endtask

   task automatic test_function();
      logic [7:0] vec [5];
      logic       exp [5];
      vec[0] = 8'b10101000; exp[0] = 1'b1;
      vec[1] = 8'b11110000; exp[1] = 1'b0;
      vec[2] = 8'h00;       exp[2] = 1'b0;
      vec[3] = 8'hFF;       exp[3] = 1'b0;
      vec[4] = 8'h01;       exp[4] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (uut.parity_even(vec[i]) !== exp[i]) begin
            errors++;
            $display("FAIL func_parity_%h: got %b, expected %b", vec[i], uut.parity_even(vec[i]), exp[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vec [3];
      logic       par [3];
      vec[0] = 8'hA8; par[0] = 1'b1;
      vec[1] = 8'hF0; par[1] = 1'b0;
      vec[2] = 8'h01; par[2] = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = vec[i]; in_par = par[i];
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready_%0d: got %b, expected 1", i, in_ready); end
         @(posedge clk); #1;
         checks += 2;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid_%0d: got %b, expected 1", i, out_valid); end
         if (out_par !== par[i]) begin errors++; $display("FAIL b2b_out_par_%0d: got %b, expected %b", i, out_par, par[i]); end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_valid: got %b, expected 0", out_valid); end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h07; in_par = 1'b1;
      @(posedge clk); #1;
      in_data = 8'h55; in_par = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks += 3;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %b, expected 0", i, in_ready); end
         if (out_data !== 8'h07) begin errors++; $display("FAIL bp_out_data_%0d: got %h, expected 07", i, out_data); end
         if (out_par !== 1'b1) begin errors++; $display("FAIL bp_out_par_%0d: got %b, expected 1", i, out_par); end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (out_data !== 8'h55) begin errors++; $display("FAIL bp_next_beat: got %h, expected 55", out_data); end
      @(posedge clk); #1;
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL bp_lost_beat: got %0d pending, expected 0", sb.size()); end
   endtask

   task automatic test_checker();
      out_ready = 1'b1;
      checks++;
      if (err_cnt !== 16'd0) begin errors++; $display("FAIL chk_cnt_start: got %0d, expected 0", err_cnt); end
      in_valid = 1'b1; in_data = 8'hA8; in_par = 1'b0;
      @(posedge clk); #1;
      checks += 3;
      if (out_err !== CHK) begin errors++; $display("FAIL chk_err_a8: got %b, expected %b", out_err, CHK); end
      if (err_cnt !== 16'(CHK)) begin errors++; $display("FAIL chk_cnt_a8: got %0d, expected %0d", err_cnt, CHK); end
      if (err_cnt !== 16'(cnt_model)) begin errors++; $display("FAIL chk_cnt_model_a8: got %0d, expected %0d", err_cnt, cnt_model); end
      in_data = 8'hF0; in_par = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks += 2;
      if (out_err !== 1'b0) begin errors++; $display("FAIL chk_err_f0: got %b, expected 0", out_err); end
      if (err_cnt !== 16'(CHK)) begin errors++; $display("FAIL chk_cnt_f0: got %0d, expected %0d", err_cnt, CHK); end
      @(posedge clk); #1;
   endtask

   task automatic test_saturation();
      int exp_cnt;
      v2 = 1'b1; d2 = 8'hA8; p2 = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         exp_cnt = CHK ? ((k > 3) ? 3 : k) : 0;
         checks++;
         if (cnt2 !== 2'(exp_cnt)) begin errors++; $display("FAIL sat_cnt_%0d: got %0d, expected %0d", k, cnt2, exp_cnt); end
      end
      clr2 = 1'b1;
      @(posedge clk); #1;
      checks += 2;
      if (cnt2 !== 2'd0) begin errors++; $display("FAIL sat_clr_wins: got %0d, expected 0", cnt2); end
      if (oe2 !== CHK) begin errors++; $display("FAIL sat_out_err: got %b, expected %b", oe2, CHK); end
      v2 = 1'b0; clr2 = 1'b0;
   endtask

   task automatic test_reset_midhold();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h3C; in_par = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks += 2;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL rh_held_valid: got %b, expected 1", out_valid); end
      if (err_cnt !== 16'(2 * CHK)) begin errors++; $display("FAIL rh_cnt_before: got %0d, expected %0d", err_cnt, 2 * CHK); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks += 4;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rh_out_valid: got %b, expected 0", out_valid); end
      if (out_data !== 8'h00) begin errors++; $display("FAIL rh_out_data: got %h, expected 00", out_data); end
      if (err_cnt !== 16'd0) begin errors++; $display("FAIL rh_err_cnt: got %0d, expected 0", err_cnt); end
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rh_in_ready: got %b, expected 1", in_ready); end
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rh_no_replay: got %b, expected 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_function();
      test_back_to_back();
      test_backpressure();
      test_checker();
      test_saturation();
      test_reset_midhold();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL end_pending: got %0d, expected 0", sb.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
